// File: rtl/sum_tx_sequencer.sv
// sum_tx_sequencer: streams "A+B=SS" (plus CR LF when SUMTX_CRLF_EN is defined) to uart_tx.
// Operands and sum are snapshotted on request; each byte waits for the uart busy handshake.
module sum_tx_sequencer #(
  parameter int BUSY_WAIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       send_n,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  input  logic [4:0] sum,
  input  logic       uartbusy,
  output logic       uart_tx_en,
  output logic [7:0] uart_tx_data,
  output logic       seq_busy,
  output logic [2:0] byte_idx,
  output logic       tx_err
);
`ifdef SUMTX_CRLF_EN
  localparam int FRAME_LEN = 8;
`else
  localparam int FRAME_LEN = 6;
`endif
  localparam logic [2:0] LAST = 3'(FRAME_LEN - 1);
  localparam int CW = $clog2(BUSY_WAIT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, ARM, STROBE, WAIT_HI, WAIT_LO, NEXT, DONE} state_t;
  state_t state;
  logic [2:0] sync;
  logic [3:0] a_q, b_q;
  logic [4:0] s_q;
  logic [CW-1:0] cnt;
  logic [1:0] tens;
  logic [3:0] ones;
  logic [2:0] sel;
  logic [7:0] frame_byte;
  logic req;
  function automatic logic [7:0] hex(input logic [3:0] x);
    return x <= 4'd9 ? 8'h30 + {4'h0, x} : 8'h37 + {4'h0, x};
  endfunction
  assign req  = sync[2] & ~sync[1];
  assign tens = s_q >= 5'd30 ? 2'd3 : s_q >= 5'd20 ? 2'd2 : s_q >= 5'd10 ? 2'd1 : 2'd0;
  assign ones = 4'(s_q - 5'd10 * {3'b0, tens});
  // LOAD presents byte 0; NEXT presents the byte after the current one
  assign sel  = state == NEXT ? byte_idx + 3'd1 : 3'd0;
  always_comb begin
    frame_byte = 8'h0A;
    case (sel)
      3'd0: frame_byte = hex(a_q);
      3'd1: frame_byte = 8'h2B;
      3'd2: frame_byte = hex(b_q);
      3'd3: frame_byte = 8'h3D;
      3'd4: frame_byte = 8'h30 + {6'h0, tens};
      3'd5: frame_byte = 8'h30 + {4'h0, ones};
      3'd6: frame_byte = 8'h0D;
      default: frame_byte = 8'h0A;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      sync         <= 3'b111;
      a_q          <= '0;
      b_q          <= '0;
      s_q          <= '0;
      cnt          <= '0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
      seq_busy     <= 1'b0;
      byte_idx     <= '0;
      tx_err       <= 1'b0;
    end else begin
      sync       <= {sync[1:0], send_n};
      uart_tx_en <= 1'b0;
      case (state)
        IDLE: if (req) begin
          a_q      <= op_a;
          b_q      <= op_b;
          s_q      <= sum;
          byte_idx <= '0;
          tx_err   <= 1'b0;
          seq_busy <= 1'b1;
          state    <= LOAD;
        end
        LOAD: begin
          uart_tx_data <= frame_byte;
          state        <= ARM;
        end
        ARM: if (!uartbusy) begin
          uart_tx_en <= 1'b1;
          state      <= STROBE;
        end
        STROBE: begin
          cnt   <= '0;
          state <= WAIT_HI;
        end
        WAIT_HI: if (uartbusy) state <= WAIT_LO;
        else if (cnt == CW'(BUSY_WAIT - 1)) begin
          tx_err <= 1'b1;
          state  <= NEXT;
        end else cnt <= cnt + 1'b1;
        WAIT_LO: if (!uartbusy) state <= NEXT;
        NEXT: if (byte_idx == LAST) state <= DONE;
        else begin
          byte_idx     <= byte_idx + 3'd1;
          uart_tx_data <= frame_byte;
          state        <= ARM;
        end
        DONE: begin
          seq_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
